// File: rtl/matrix_store_writer.sv
// Streams a matrix (3-word header + rows*cols elements) into slot id of a block-partitioned BRAM.
// Optional idle-data abort is enabled by defining MATRIX_WRITER_TIMEOUT_EN.
module matrix_store_writer #(
    parameter int BLOCK_SIZE     = 1152,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            write_matrix_id,
    input  logic [7:0]            write_rows,
    input  logic [7:0]            write_cols,
    input  logic [0:7][7:0]       write_name,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic                  busy,
    output logic                  error
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA, DONE, ERR} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [15:0]           remaining;
    logic [0:7][7:0]       name_q;

    // Request decode, evaluated only in IDLE where the request can be accepted.
    logic [15:0]           req_count;
    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_base;

    assign req_count = 16'(write_rows) * 16'(write_cols);
    assign req_bad   = (write_rows == 8'd0) || (write_cols == 8'd0) ||
                       (req_count > 16'(BLOCK_SIZE - 3));
    assign req_base  = ADDR_WIDTH'(write_matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);

`ifdef MATRIX_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, because the BRAM address/data outputs must read 0 after reset.
            state        <= IDLE;
            write_ready  <= 1'b1;
            writer_ready <= 1'b0;
            write_done   <= 1'b0;
            bram_wr_en   <= 1'b0;
            bram_wr_addr <= '0;
            bram_wr_data <= '0;
            busy         <= 1'b0;
            error        <= 1'b0;
            next_addr    <= '0;
            remaining    <= '0;
            name_q       <= '0;
`ifdef MATRIX_WRITER_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
        end else begin
            bram_wr_en <= 1'b0;
            write_done <= 1'b0;
            error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_request) begin
                        write_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (req_bad) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state        <= HDR0;
                            bram_wr_en   <= 1'b1;
                            bram_wr_addr <= req_base;
                            bram_wr_data <= DATA_WIDTH'({16'h0, write_rows, write_cols});
                            next_addr    <= req_base + ADDR_WIDTH'(1);
                            remaining    <= req_count;
                            name_q       <= write_name;
                        end
                    end
                end
                HDR0: begin
                    state        <= HDR1;
                    bram_wr_en   <= 1'b1;
                    bram_wr_addr <= next_addr;
                    bram_wr_data <= DATA_WIDTH'(name_q[0:3]);
                    next_addr    <= next_addr + ADDR_WIDTH'(1);
                end
                HDR1: begin
                    state        <= HDR2;
                    bram_wr_en   <= 1'b1;
                    bram_wr_addr <= next_addr;
                    bram_wr_data <= DATA_WIDTH'(name_q[4:7]);
                    next_addr    <= next_addr + ADDR_WIDTH'(1);
                end
                HDR2: begin
                    state        <= DATA;
                    writer_ready <= 1'b1;
`ifdef MATRIX_WRITER_TIMEOUT_EN
                    idle_cnt     <= '0;
`endif
                end
                DATA: begin
                    if (write_data_valid) begin
                        bram_wr_en   <= 1'b1;
                        bram_wr_addr <= next_addr;
                        bram_wr_data <= write_data;
                        next_addr    <= next_addr + ADDR_WIDTH'(1);
                        remaining    <= remaining - 16'd1;
`ifdef MATRIX_WRITER_TIMEOUT_EN
                        idle_cnt     <= '0;
`endif
                        if (remaining == 16'd1) begin
                            state        <= DONE;
                            writer_ready <= 1'b0;
                            write_done   <= 1'b1;
                        end
                    end
`ifdef MATRIX_WRITER_TIMEOUT_EN
                    else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state        <= ERR;
                        writer_ready <= 1'b0;
                        error        <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
`endif
                end
                DONE, ERR: begin
                    state       <= IDLE;
                    write_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    write_ready  <= 1'b1;
                    writer_ready <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_store_writer.sv
// Directed testbench for matrix_store_writer; outputs are sampled 1ns after each rising edge.
// Define MATRIX_WRITER_TIMEOUT_EN for both files to exercise the idle-data abort.
module tb_matrix_store_writer;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             write_request = 1'b0;
    logic             write_ready;
    logic [2:0]       write_matrix_id = '0;
    logic [7:0]       write_rows = '0;
    logic [7:0]       write_cols = '0;
    logic [0:7][7:0]  write_name = '0;
    logic [31:0]      write_data = '0;
    logic             write_data_valid = 1'b0;
    logic             writer_ready;
    logic             write_done;
    logic             bram_wr_en;
    logic [13:0]      bram_wr_addr;
    logic [31:0]      bram_wr_data;
    logic             busy;
    logic             error;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int done_count = 0;
    int err_count = 0;
    logic [31:0] mem [int];

    matrix_store_writer #(
        .BLOCK_SIZE(1152), .DATA_WIDTH(32), .ADDR_WIDTH(14), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .write_request(write_request), .write_ready(write_ready),
        .write_matrix_id(write_matrix_id), .write_rows(write_rows),
        .write_cols(write_cols), .write_name(write_name),
        .write_data(write_data), .write_data_valid(write_data_valid),
        .writer_ready(writer_ready), .write_done(write_done),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // BRAM image and event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bram_wr_en) begin
            mem[int'(bram_wr_addr)] = bram_wr_data;
            wr_count++;
        end
        if (write_done) done_count++;
        if (error) err_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                           input logic [63:0] nm);
        write_request   = 1'b1;
        write_matrix_id = id;
        write_rows      = r;
        write_cols      = c;
        write_name      = nm;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL reset_write_ready got %b exp 1", write_ready); end
        tests++; if ({writer_ready, write_done, bram_wr_en, busy, error} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b exp 00000", {writer_ready, write_done, bram_wr_en, busy, error}); end
        tests++; if (bram_wr_addr !== 14'd0 || bram_wr_data !== 32'd0) begin fails++; $display("FAIL reset_bus got addr %0d data %h exp 0 0", bram_wr_addr, bram_wr_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_store();
        int w0 = wr_count;
        int d0 = done_count;
        request(3'd2, 8'd2, 8'd3, "MATRIX_A");
        step();
        write_request = 1'b0;
        tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data} !== {1'b1, 14'd2304, 32'h00000203}) begin fails++; $display("FAIL basic_hdr0 got en %b addr %0d data %h exp 1 2304 00000203", bram_wr_en, bram_wr_addr, bram_wr_data); end
        tests++; if ({busy, write_ready} !== 2'b10) begin fails++; $display("FAIL basic_busy got busy %b ready %b exp 1 0", busy, write_ready); end
        step();
        tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data} !== {1'b1, 14'd2305, 32'h4D415452}) begin fails++; $display("FAIL basic_hdr1 got en %b addr %0d data %h exp 1 2305 4d415452", bram_wr_en, bram_wr_addr, bram_wr_data); end
        step();
        tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data, writer_ready} !== {1'b1, 14'd2306, 32'h49585F41, 1'b0}) begin fails++; $display("FAIL basic_hdr2 got en %b addr %0d data %h wrdy %b exp 1 2306 49585f41 0", bram_wr_en, bram_wr_addr, bram_wr_data, writer_ready); end
        step();
        tests++; if ({writer_ready, bram_wr_en} !== 2'b10) begin fails++; $display("FAIL basic_data_entry got wrdy %b en %b exp 1 0", writer_ready, bram_wr_en); end
        for (int i = 1; i <= 6; i++) begin
            write_data_valid = 1'b1;
            write_data = 32'(i);
            step();
            tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data, write_done, writer_ready} !== {1'b1, 14'(2306 + i), 32'(i), i == 6, i != 6}) begin fails++; $display("FAIL basic_elem%0d got en %b addr %0d data %0d done %b wrdy %b", i, bram_wr_en, bram_wr_addr, bram_wr_data, write_done, writer_ready); end
        end
        write_data_valid = 1'b0;
        step();
        tests++; if ({write_ready, busy, write_done, bram_wr_en} !== 4'b1000) begin fails++; $display("FAIL basic_idle got rdy %b busy %b done %b en %b exp 1 0 0 0", write_ready, busy, write_done, bram_wr_en); end
        tests++; if (wr_count - w0 != 9 || done_count - d0 != 1) begin fails++; $display("FAIL basic_counts got writes %0d dones %0d exp 9 1", wr_count - w0, done_count - d0); end
        tests++; if (mem[2304] !== 32'h203 || mem[2312] !== 32'd6) begin fails++; $display("FAIL basic_mem got %h %h exp 00000203 00000006", mem[2304], mem[2312]); end
    endtask

    task automatic reject_one(input logic [7:0] r, input logic [7:0] c);
        request(3'd1, r, c, "BAD_SIZE");
        step();
        write_request = 1'b0;
        tests++; if ({error, bram_wr_en, write_ready, busy} !== 4'b1001) begin fails++; $display("FAIL reject_%0dx%0d_t1 got err %b en %b rdy %b busy %b exp 1 0 0 1", r, c, error, bram_wr_en, write_ready, busy); end
        step();
        tests++; if ({write_ready, error, busy, bram_wr_en} !== 4'b1000) begin fails++; $display("FAIL reject_%0dx%0d_t2 got rdy %b err %b busy %b en %b exp 1 0 0 0", r, c, write_ready, error, busy, bram_wr_en); end
    endtask

    task automatic test_reject();
        int w0 = wr_count;
        int e0 = err_count;
        reject_one(8'd0, 8'd5);
        reject_one(8'd34, 8'd34);
        reject_one(8'd5, 8'd230);
        tests++; if (wr_count - w0 != 0 || err_count - e0 != 3) begin fails++; $display("FAIL reject_counts got writes %0d errors %0d exp 0 3", wr_count - w0, err_count - e0); end
        // 7x164 = 1148 fits; accept and then abandon it with a reset.
        request(3'd6, 8'd7, 8'd164, "BIG_OKAY");
        step();
        write_request = 1'b0;
        tests++; if ({error, bram_wr_en, bram_wr_addr, bram_wr_data} !== {1'b0, 1'b1, 14'd6912, 32'h000007A4}) begin fails++; $display("FAIL reject_limit_accept got err %b en %b addr %0d data %h exp 0 1 6912 000007a4", error, bram_wr_en, bram_wr_addr, bram_wr_data); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single_element();
        int w0 = wr_count;
        int d0 = done_count;
        request(3'd0, 8'd1, 8'd1, "ONE_BY_1");
        step();
        write_request = 1'b0;
        step(); step(); step();
        write_data_valid = 1'b1;
        write_data = 32'hAB;
        step();
        tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data, write_done, writer_ready} !== {1'b1, 14'd3, 32'hAB, 1'b1, 1'b0}) begin fails++; $display("FAIL single_write got en %b addr %0d data %h done %b wrdy %b", bram_wr_en, bram_wr_addr, bram_wr_data, write_done, writer_ready); end
        step();
        tests++; if ({bram_wr_en, write_ready, writer_ready} !== 3'b010) begin fails++; $display("FAIL single_hold1 got en %b rdy %b wrdy %b exp 0 1 0", bram_wr_en, write_ready, writer_ready); end
        step();
        tests++; if (bram_wr_en !== 1'b0) begin fails++; $display("FAIL single_hold2 got en %b exp 0", bram_wr_en); end
        write_data_valid = 1'b0;
        tests++; if (wr_count - w0 != 4 || done_count - d0 != 1) begin fails++; $display("FAIL single_counts got writes %0d dones %0d exp 4 1", wr_count - w0, done_count - d0); end
    endtask

    task automatic test_back_to_back();
        int w0 = wr_count;
        int d0 = done_count;
        int k = 0;
        bit pat [6] = '{1, 0, 1, 1, 0, 1};
        request(3'd7, 8'd2, 8'd2, "GAPPED22");
        step();
        write_request = 1'b0;
        step();
        request(3'd1, 8'd1, 8'd1, "SECOND_1");
        step(); step();
        for (int j = 0; j < 6; j++) begin
            write_data_valid = pat[j];
            write_data = 32'(100 + j);
            step();
            if (pat[j]) begin
                tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data, write_done} !== {1'b1, 14'(8067 + k), 32'(100 + j), k == 3}) begin fails++; $display("FAIL gap_elem%0d got en %b addr %0d data %0d done %b", k, bram_wr_en, bram_wr_addr, bram_wr_data, write_done); end
                k++;
            end else begin
                tests++; if ({bram_wr_en, writer_ready} !== 2'b01) begin fails++; $display("FAIL gap_idle%0d got en %b wrdy %b exp 0 1", j, bram_wr_en, writer_ready); end
            end
        end
        write_data_valid = 1'b0;
        tests++; if (write_ready !== 1'b0) begin fails++; $display("FAIL gap_done_ready got %b exp 0", write_ready); end
        step();
        tests++; if (write_ready !== 1'b1) begin fails++; $display("FAIL gap_idle_ready got %b exp 1", write_ready); end
        step();
        write_request = 1'b0;
        tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data} !== {1'b1, 14'd1152, 32'h101}) begin fails++; $display("FAIL gap_second_hdr got en %b addr %0d data %h exp 1 1152 00000101", bram_wr_en, bram_wr_addr, bram_wr_data); end
        step(); step(); step();
        write_data_valid = 1'b1;
        write_data = 32'h55;
        step();
        write_data_valid = 1'b0;
        tests++; if ({bram_wr_addr, write_done} !== {14'd1155, 1'b1}) begin fails++; $display("FAIL gap_second_elem got addr %0d done %b exp 1155 1", bram_wr_addr, write_done); end
        step();
        tests++; if (wr_count - w0 != 11 || done_count - d0 != 2) begin fails++; $display("FAIL gap_counts got writes %0d dones %0d exp 11 2", wr_count - w0, done_count - d0); end
    endtask

    task automatic test_reset_mid_store();
        int d0 = done_count;
        request(3'd3, 8'd2, 8'd2, "PARTIAL!");
        step();
        write_request = 1'b0;
        step(); step(); step();
        write_data_valid = 1'b1;
        write_data = 32'h11;
        step();
        write_data = 32'h22;
        step();
        write_data_valid = 1'b0;
        rst_n = 1'b0;
        step();
        tests++; if ({write_ready, writer_ready, write_done, bram_wr_en, busy, error} !== 6'b100000 || bram_wr_addr !== 14'd0) begin fails++; $display("FAIL midreset_outputs got rdy %b wrdy %b done %b en %b busy %b err %b addr %0d", write_ready, writer_ready, write_done, bram_wr_en, busy, error, bram_wr_addr); end
        rst_n = 1'b1;
        request(3'd4, 8'd1, 8'd2, "NEXT_1X2");
        step();
        write_request = 1'b0;
        tests++; if ({bram_wr_en, bram_wr_addr, bram_wr_data} !== {1'b1, 14'd4608, 32'h102}) begin fails++; $display("FAIL midreset_new_hdr got en %b addr %0d data %h exp 1 4608 00000102", bram_wr_en, bram_wr_addr, bram_wr_data); end
        step(); step(); step();
        write_data_valid = 1'b1;
        write_data = 32'h33;
        step();
        write_data = 32'h44;
        step();
        write_data_valid = 1'b0;
        tests++; if ({bram_wr_addr, bram_wr_data, write_done} !== {14'd4612, 32'h44, 1'b1}) begin fails++; $display("FAIL midreset_new_last got addr %0d data %h done %b exp 4612 44 1", bram_wr_addr, bram_wr_data, write_done); end
        step();
        tests++; if (mem[3459] !== 32'h11 || mem[3460] !== 32'h22 || mem[4611] !== 32'h33) begin fails++; $display("FAIL midreset_mem got %h %h %h exp 11 22 33", mem[3459], mem[3460], mem[4611]); end
        tests++; if (done_count - d0 != 1) begin fails++; $display("FAIL midreset_dones got %0d exp 1", done_count - d0); end
    endtask

`ifdef MATRIX_WRITER_TIMEOUT_EN
    task automatic test_timeout();
        int d0 = done_count;
        int e0 = err_count;
        request(3'd5, 8'd1, 8'd1, "TIMEOUT!");
        step();
        write_request = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 15; i++) step();
        tests++; if ({writer_ready, error} !== 2'b10) begin fails++; $display("FAIL timeout_before got wrdy %b err %b exp 1 0", writer_ready, error); end
        step();
        tests++; if ({writer_ready, error, busy} !== 3'b011) begin fails++; $display("FAIL timeout_fire got wrdy %b err %b busy %b exp 0 1 1", writer_ready, error, busy); end
        step();
        tests++; if ({write_ready, busy, error} !== 3'b100) begin fails++; $display("FAIL timeout_idle got rdy %b busy %b err %b exp 1 0 0", write_ready, busy, error); end
        tests++; if (done_count - d0 != 0 || err_count - e0 != 1) begin fails++; $display("FAIL timeout_counts got dones %0d errors %0d exp 0 1", done_count - d0, err_count - e0); end
    endtask
`else
    task automatic test_timeout();
        request(3'd5, 8'd1, 8'd1, "NO_LIMIT");
        step();
        write_request = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 40; i++) step();
        tests++; if ({writer_ready, error, busy} !== 3'b101) begin fails++; $display("FAIL notimeout_wait got wrdy %b err %b busy %b exp 1 0 1", writer_ready, error, busy); end
        write_data_valid = 1'b1;
        write_data = 32'h77;
        step();
        write_data_valid = 1'b0;
        tests++; if ({bram_wr_addr, write_done} !== {14'd5763, 1'b1}) begin fails++; $display("FAIL notimeout_finish got addr %0d done %b exp 5763 1", bram_wr_addr, write_done); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_store();
        test_reject();
        test_single_element();
        test_back_to_back();
        test_reset_mid_store();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
